te_block_packer: RTL and testbench

Parametrised commit-to-trace block builder sitting between the CVA6 commit stage and the trace encoder. It takes up to NRET classified retirements per cycle and groups them into E-trace instruction blocks (iretire/ilastsize/itype/iaddr/cause/tval/priv). Closed blocks are buffered in a multi-push block FIFO and emitted up to N per cycle over a valid/ready handshake, with commit-side flow-control and overflow reporting.

---
 rtl/te_block_packer.sv | 179 +++++++++++++++++
 tb/tb_te_block_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_block_packer.sv
// te_block_packer: groups classified commit-stage retirements into E-trace
// instruction blocks, buffers closed blocks in a multi-push FIFO and hands them
// to the trace encoder up to N per transfer.
module te_block_packer #(
  parameter int NRET        = 2,
  parameter int N           = 2,
  parameter int DEPTH       = 16,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 15,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NRET-1:0]                      valid_i,
  input  logic [NRET-1:0][XLEN-1:0]            pc_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0]       itype_i,
  input  logic [NRET-1:0]                      compressed_i,
  input  logic [PRIV_LEN-1:0]                  priv_i,
  input  logic [XLEN-1:0]                      cause_i,
  input  logic [XLEN-1:0]                      tval_i,
  output logic                                 commit_ready_o,
  output logic                                 overflow_o,
  output logic [N-1:0]                         valid_o,
  input  logic                                 ready_i,
  output logic [N-1:0][IRETIRE_LEN-1:0]        iretire_o,
  output logic [N-1:0]                         ilastsize_o,
  output logic [N-1:0][ITYPE_LEN-1:0]          itype_o,
  output logic [N-1:0][XLEN-1:0]               iaddr_o,
  output logic [N-1:0][PRIV_LEN-1:0]           priv_o,
  output logic [N-1:0][XLEN-1:0]               cause_o,
  output logic [N-1:0][XLEN-1:0]               tval_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NCL = NRET + 1;
  localparam int KW  = $clog2(NCL + 1);
  localparam int RW  = IRETIRE_LEN + 1;
  localparam logic [RW-1:0] IMAX = {1'b0, {IRETIRE_LEN{1'b1}}};

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
  } blk_t;

  blk_t                   mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_next, n_pop;

  logic                   open_q, open_lastc_q;
  logic [XLEN-1:0]        open_addr_q;
  logic [IRETIRE_LEN-1:0] open_ret_q;
  logic [PRIV_LEN-1:0]    open_priv_q;

  blk_t                   cl [NCL];
  logic [KW-1:0]          ncl;
  logic                   n_open, n_lastc;
  logic [XLEN-1:0]        n_addr;
  logic [RW-1:0]          n_ret, sz;
  logic [PRIV_LEN-1:0]    n_priv;
  logic                   any_valid, accept, is_trap;
  blk_t                   lane_blk [N];

  // Walk this cycle's retirements in slot order, producing the closed blocks
  // and the next open-block state. Input arriving while not ready is dropped
  // and also kills the open block so the next accepted slot starts clean.
  always_comb begin
    any_valid = |valid_i;
    accept    = any_valid & commit_ready_o;
    n_open    = open_q;
    n_addr    = open_addr_q;
    n_ret     = {1'b0, open_ret_q};
    n_priv    = open_priv_q;
    n_lastc   = open_lastc_q;
    ncl       = '0;
    sz        = '0;
    is_trap   = 1'b0;
    for (int j = 0; j < NCL; j++) cl[j] = '0;
    if (accept) begin
      if (n_open && (n_priv != priv_i)) begin
        cl[ncl] = '{iaddr: n_addr, iretire: n_ret[IRETIRE_LEN-1:0], ilastsize: ~n_lastc,
                    itype: '0, priv: n_priv, cause: '0, tval: '0};
        ncl     = ncl + KW'(1);
        n_open  = 1'b0;
      end
      for (int i = 0; i < NRET; i++) begin
        if (valid_i[i]) begin
          sz = compressed_i[i] ? RW'(1) : RW'(2);
          if (n_open && ((n_ret + sz) > IMAX)) begin
            cl[ncl] = '{iaddr: n_addr, iretire: n_ret[IRETIRE_LEN-1:0], ilastsize: ~n_lastc,
                        itype: '0, priv: n_priv, cause: '0, tval: '0};
            ncl     = ncl + KW'(1);
            n_open  = 1'b0;
          end
          if (!n_open) begin
            n_open = 1'b1;
            n_addr = pc_i[i];
            n_ret  = '0;
            n_priv = priv_i;
          end
          n_ret   = n_ret + sz;
          n_lastc = compressed_i[i];
          if (itype_i[i] != '0) begin
            is_trap = (itype_i[i] == ITYPE_LEN'(1)) || (itype_i[i] == ITYPE_LEN'(2));
            cl[ncl] = '{iaddr: n_addr, iretire: n_ret[IRETIRE_LEN-1:0], ilastsize: ~n_lastc,
                        itype: itype_i[i], priv: n_priv,
                        cause: is_trap ? cause_i : '0, tval: is_trap ? tval_i : '0};
            ncl     = ncl + KW'(1);
            n_open  = 1'b0;
          end
        end
      end
    end else if (any_valid) begin
      n_open = 1'b0;
    end
  end

  // Occupancy bookkeeping: a transfer takes every valid lane at once.
  always_comb begin
    for (int k = 0; k < N; k++) valid_o[k] = count_q > CW'(k);
    n_pop      = (valid_o[0] && ready_i) ? ((count_q > CW'(N)) ? CW'(N) : count_q) : '0;
    count_next = count_q + CW'(ncl) - n_pop;
  end

  // Present FIFO entries head..head+N-1 on the lanes; empty lanes read zero.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lane_blk[k]    = valid_o[k] ? mem_q[rd_ptr_q + PW'(k)] : '0;
      iaddr_o[k]     = lane_blk[k].iaddr;
      iretire_o[k]   = lane_blk[k].iretire;
      ilastsize_o[k] = lane_blk[k].ilastsize;
      itype_o[k]     = lane_blk[k].itype;
      priv_o[k]      = lane_blk[k].priv;
      cause_o[k]     = lane_blk[k].cause;
      tval_o[k]      = lane_blk[k].tval;
    end
  end

  // Control state: pointers, count, open block, flow-control flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      open_q         <= 1'b0;
      open_addr_q    <= '0;
      open_ret_q     <= '0;
      open_priv_q    <= '0;
      open_lastc_q   <= 1'b0;
      commit_ready_o <= 1'b1;
      overflow_o     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_q + PW'(ncl);
      rd_ptr_q       <= rd_ptr_q + PW'(n_pop);
      count_q        <= count_next;
      open_q         <= n_open;
      open_addr_q    <= n_addr;
      open_ret_q     <= n_ret[IRETIRE_LEN-1:0];
      open_priv_q    <= n_priv;
      open_lastc_q   <= n_lastc;
      commit_ready_o <= (CW'(DEPTH) - count_next) >= CW'(NRET + 1);
      overflow_o     <= any_valid & ~commit_ready_o;
    end
  end

  // Block storage: closures land in consecutive slots from the write pointer.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NCL; j++) begin
      if (rst_ni && (KW'(j) < ncl)) mem_q[wr_ptr_q + PW'(j)] <= cl[j];
    end
  end

endmodule

// File: tb/tb_te_block_packer.sv
// Bench for te_block_packer: directed vector table, hand-written back-pressure
// sequence and randomized traffic against a queue-based reference model.
module tb_te_block_packer;

  localparam int NRET = 2, N = 2, DEPTH = 16, XLEN = 64, IL = 4, IT = 3, PL = 2;
  localparam int IMAX = (1 << IL) - 1;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic [NRET-1:0]            valid_i;
  logic [NRET-1:0][XLEN-1:0]  pc_i;
  logic [NRET-1:0][IT-1:0]    itype_i;
  logic [NRET-1:0]            compressed_i;
  logic [PL-1:0]              priv_i;
  logic [XLEN-1:0]            cause_i, tval_i;
  logic                       commit_ready_o, overflow_o, ready_i;
  logic [N-1:0]               valid_o;
  logic [N-1:0][IL-1:0]       iretire_o;
  logic [N-1:0]               ilastsize_o;
  logic [N-1:0][IT-1:0]       itype_o;
  logic [N-1:0][XLEN-1:0]     iaddr_o, cause_o, tval_o;
  logic [N-1:0][PL-1:0]       priv_o;

  te_block_packer #(.NRET(NRET), .N(N), .DEPTH(DEPTH), .XLEN(XLEN), .IRETIRE_LEN(IL),
                    .ITYPE_LEN(IT), .PRIV_LEN(PL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i), .itype_i(itype_i),
    .compressed_i(compressed_i), .priv_i(priv_i), .cause_i(cause_i), .tval_i(tval_i),
    .commit_ready_o(commit_ready_o), .overflow_o(overflow_o), .valid_o(valid_o),
    .ready_i(ready_i), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
    .iaddr_o(iaddr_o), .priv_o(priv_o), .cause_o(cause_o), .tval_o(tval_o));

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] iaddr;
    int          iret;
    logic        last;
    logic [2:0]  ity;
    logic [1:0]  prv;
    logic [63:0] cause;
    logic [63:0] tval;
  } blk_t;

  blk_t        q[$];
  bit          m_open = 0;
  logic [63:0] m_addr;
  int          m_cnt;
  bit          m_lastc;
  logic [1:0]  m_priv;
  bit          exp_ready = 1;
  bit          exp_ovf = 0;

  task automatic m_close(input logic [2:0] ty, input logic [63:0] c, input logic [63:0] t);
    blk_t b;
    b.iaddr = m_addr; b.iret = m_cnt; b.last = !m_lastc; b.ity = ty;
    b.prv = m_priv; b.cause = c; b.tval = t;
    q.push_back(b);
    m_open = 0;
  endtask

  // Effect of the coming clock edge given the inputs now applied.
  task automatic model_step();
    int npop, sz;
    if (!rst_ni) begin
      q.delete(); m_open = 0; exp_ready = 1; exp_ovf = 0;
      return;
    end
    npop = (ready_i && q.size() > 0) ? ((q.size() < N) ? q.size() : N) : 0;
    repeat (npop) void'(q.pop_front());
    exp_ovf = 0;
    if (valid_i != '0) begin
      if (!exp_ready) begin
        exp_ovf = 1;
        m_open  = 0;
      end else begin
        if (m_open && m_priv != priv_i) m_close(3'd0, 64'd0, 64'd0);
        for (int i = 0; i < NRET; i++) begin
          if (valid_i[i]) begin
            sz = compressed_i[i] ? 1 : 2;
            if (m_open && (m_cnt + sz > IMAX)) m_close(3'd0, 64'd0, 64'd0);
            if (!m_open) begin
              m_open = 1; m_addr = pc_i[i]; m_cnt = 0; m_priv = priv_i;
            end
            m_cnt   += sz;
            m_lastc = compressed_i[i];
            if (itype_i[i] == 3'd1 || itype_i[i] == 3'd2) m_close(itype_i[i], cause_i, tval_i);
            else if (itype_i[i] != 3'd0) m_close(itype_i[i], 64'd0, 64'd0);
          end
        end
      end
    end
    exp_ready = (DEPTH - q.size()) >= NRET + 1;
  endtask

  task automatic check_model();
    logic [N-1:0] ev;
    for (int k = 0; k < N; k++) ev[k] = (q.size() > k);
    chk("commit_ready", 64'(commit_ready_o), 64'(exp_ready));
    chk("overflow", 64'(overflow_o), 64'(exp_ovf));
    chk("valid_o", 64'(valid_o), 64'(ev));
    for (int k = 0; k < N; k++) begin
      if (k < q.size()) begin
        chk("lane_iaddr", iaddr_o[k], q[k].iaddr);
        chk("lane_iretire", 64'(iretire_o[k]), 64'(q[k].iret));
        chk("lane_ilastsize", 64'(ilastsize_o[k]), 64'(q[k].last));
        chk("lane_itype", 64'(itype_o[k]), 64'(q[k].ity));
        chk("lane_priv", 64'(priv_o[k]), 64'(q[k].prv));
        chk("lane_cause", cause_o[k], q[k].cause);
        chk("lane_tval", tval_o[k], q[k].tval);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk_i);
    check_model();
  endtask

  task automatic set_in(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                        input logic [2:0] t0, input logic [2:0] t1, input logic [1:0] cm,
                        input logic [1:0] pr, input logic [63:0] c, input logic [63:0] t);
    valid_i = v; pc_i[0] = p0; pc_i[1] = p1; itype_i[0] = t0; itype_i[1] = t1;
    compressed_i = cm; priv_i = pr; cause_i = c; tval_i = t;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  vld;  logic [63:0] pc0;  logic [63:0] pc1;
    logic [2:0]  it0;  logic [2:0]  it1;  logic [1:0]  cmp;  logic [1:0] prv;
    logic [63:0] cause; logic [63:0] tval;
    logic [1:0]  ev;   logic [63:0] a0;   int r0; logic l0; logic [2:0] t0; logic [1:0] p0;
    logic [63:0] c0;   logic [63:0] v0;   logic [63:0] a1; int r1; logic [2:0] t1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //         vld    pc0           pc1       it0 it1 cmp  prv cause  tval      ev    a0            r0 l0 t0 p0 c0 v0       a1     r1 t1
    tbl[0]  = '{2'b01, 64'h80000000, 64'h0,    0, 0, 2'b00, 3, 0,     0,        2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[1]  = '{2'b01, 64'h80000004, 64'h0,    4, 0, 2'b01, 3, 0,     0,        2'b01, 64'h80000000, 3, 0, 4, 3, 0, 0,       0,     0, 0};
    tbl[2]  = '{2'b11, 64'h100,      64'h200,  4, 5, 2'b00, 3, 0,     0,        2'b11, 64'h100,      2, 1, 4, 3, 0, 0,       64'h200, 2, 5};
    tbl[3]  = '{2'b00, 64'h0,        64'h0,    0, 0, 2'b00, 3, 0,     0,        2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[4]  = '{2'b01, 64'h300,      64'h0,    1, 0, 2'b00, 3, 2,     64'hdead, 2'b01, 64'h300,      2, 1, 1, 3, 2, 64'hdead, 0,    0, 0};
    tbl[5]  = '{2'b01, 64'h400,      64'h0,    0, 0, 2'b00, 3, 64'h55, 64'h66,  2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[6]  = '{2'b01, 64'h404,      64'h0,    0, 0, 2'b00, 0, 0,     0,        2'b01, 64'h400,      2, 1, 0, 3, 0, 0,       0,     0, 0};
    tbl[7]  = '{2'b01, 64'h408,      64'h0,    6, 0, 2'b01, 0, 64'h77, 64'h88,  2'b01, 64'h404,      3, 0, 6, 0, 0, 0,       0,     0, 0};
    tbl[8]  = '{2'b11, 64'h1000,     64'h1002, 0, 0, 2'b00, 0, 0,     0,        2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[9]  = '{2'b11, 64'h1004,     64'h1006, 0, 0, 2'b00, 0, 0,     0,        2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[10] = '{2'b11, 64'h1008,     64'h100A, 0, 0, 2'b00, 0, 0,     0,        2'b00, 0,            0, 0, 0, 0, 0, 0,       0,     0, 0};
    tbl[11] = '{2'b11, 64'h100C,     64'h100E, 0, 0, 2'b00, 0, 0,     0,        2'b01, 64'h1000,     14, 1, 0, 0, 0, 0,      0,     0, 0};
    tbl[12] = '{2'b01, 64'h1010,     64'h0,    4, 0, 2'b00, 0, 0,     0,        2'b01, 64'h100E,     4, 1, 4, 0, 0, 0,       0,     0, 0};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0; ready_i = 1'b0;
    set_in(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk_i);
    cycle();
    cycle();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(commit_ready_o), 64'd1);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_iaddr", iaddr_o[0], 64'd0);
    chk("rst_iretire", 64'(iretire_o[0]), 64'd0);
    rst_ni = 1'b1;

    // Directed table, encoder always ready.
    ready_i = 1'b1;
    for (int r = 0; r < 13; r++) begin
      set_in(tbl[r].vld, tbl[r].pc0, tbl[r].pc1, tbl[r].it0, tbl[r].it1, tbl[r].cmp,
             tbl[r].prv, tbl[r].cause, tbl[r].tval);
      cycle();
      chk($sformatf("v%0d_valid", r), 64'(valid_o), 64'(tbl[r].ev));
      if (tbl[r].ev[0]) begin
        chk($sformatf("v%0d_iaddr0", r), iaddr_o[0], tbl[r].a0);
        chk($sformatf("v%0d_iretire0", r), 64'(iretire_o[0]), 64'(tbl[r].r0));
        chk($sformatf("v%0d_ilast0", r), 64'(ilastsize_o[0]), 64'(tbl[r].l0));
        chk($sformatf("v%0d_itype0", r), 64'(itype_o[0]), 64'(tbl[r].t0));
        chk($sformatf("v%0d_priv0", r), 64'(priv_o[0]), 64'(tbl[r].p0));
        chk($sformatf("v%0d_cause0", r), cause_o[0], tbl[r].c0);
        chk($sformatf("v%0d_tval0", r), tval_o[0], tbl[r].v0);
      end
      if (tbl[r].ev[1]) begin
        chk($sformatf("v%0d_iaddr1", r), iaddr_o[1], tbl[r].a1);
        chk($sformatf("v%0d_iretire1", r), 64'(iretire_o[1]), 64'(tbl[r].r1));
        chk($sformatf("v%0d_itype1", r), 64'(itype_o[1]), 64'(tbl[r].t1));
      end
    end
    set_in(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    cycle();
    chk("drained", 64'(valid_o), 64'd0);

    // Fill to 14 entries with the encoder stalled.
    ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      set_in(2'b11, 64'h2000 + 64'(16 * c), 64'h2008 + 64'(16 * c), 4, 5, 2'b00, 1, 0, 0);
      cycle();
      if (c == 5) chk("ready_at_12", 64'(commit_ready_o), 64'd1);
    end
    chk("full_not_ready", 64'(commit_ready_o), 64'd0);
    chk("full_valid", 64'(valid_o), 64'd3);
    set_in(2'b11, 64'h3000, 64'h3004, 0, 4, 2'b00, 1, 0, 0);
    cycle();
    chk("ovf_pulse", 64'(overflow_o), 64'd1);
    chk("ovf_head_kept", iaddr_o[0], 64'h2000);
    set_in(2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    cycle();
    chk("ovf_clear", 64'(overflow_o), 64'd0);
    chk("still_full", 64'(commit_ready_o), 64'd0);
    ready_i = 1'b1;
    cycle();
    chk("drain_ready", 64'(commit_ready_o), 64'd1);
    chk("drain_head", iaddr_o[0], 64'h2010);
    cycle();
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    cycle();
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_ready", 64'(commit_ready_o), 64'd1);
    rst_ni = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] v;
      int         last, sel;
      rst_ni = ($urandom_range(0, 499) != 0);
      v = 2'($urandom_range(0, 3));
      last = v[1] ? 1 : 0;
      for (int i = 0; i < NRET; i++) begin
        pc_i[i] = {32'h0, $urandom} & ~64'h1;
        compressed_i[i] = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        if (sel < 6) itype_i[i] = 3'd0;
        else if (sel < 8) itype_i[i] = 3'($urandom_range(3, 7));
        else itype_i[i] = 3'($urandom_range(1, 2));
        if (i != last && (itype_i[i] == 3'd1 || itype_i[i] == 3'd2)) itype_i[i] = 3'd4;
      end
      valid_i = v;
      if ($urandom_range(0, 19) == 0) priv_i = 2'($urandom_range(0, 3));
      cause_i = {$urandom, $urandom};
      tval_i  = {$urandom, $urandom};
      ready_i = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
